junction_ctrl: RTL and testbench
================================

# junction_ctrl

Arbiter and sequencer for a single-track shared section fed by two approaches (A and B). Each approach has a train-waiting request and a three-lamp signal; a single occupancy sensor covers the shared section. The block grants the section to one approach at a time with round-robin fairness and holds both signals red while the section is occupied. It also enforces a clearance interval after the train leaves, and flags any entry that was not granted.

## Interface
- CLEAR_CYCLES, 4: number of consecutive cycles with `occ` low that are required before the section is reusable. Legal range is ≥1.
- clk  in  1  clock; all state changes on the rising edge
- rstn  in  1  reset, synchronous, active-low; clock clk
- req_a  in  1  train waiting at approach A; level, held until the train enters or withdraws
- req_b  in  1  train waiting at approach B; same semantics as req_a
- occ  in  1  shared section occupied (synchronised sensor)
- green_a, yellow_a, red_a  out  1 each  approach A lamps; exactly one is high at all times
- green_b, yellow_b, red_b  out  1 each  approach B lamps; exactly one is high at all times
- busy  out  1  high whenever the state is not S_IDLE
- fault  out  1  sticky flag for unauthorised entry; cleared only by reset

## Operation
- State register, 3 bits: S_IDLE, S_GRANT_A, S_GRANT_B, S_OCC, S_FLUSH.
- Registers: `last` (1 bit, the approach granted most recently, 0=A / 1=B), `cnt` (`$clog2(CLEAR_CYCLES+1)` bits), `fault`.
- S_IDLE transitions, first match wins:
  - occ=1 → S_OCC and set fault.
  - req_a & req_b → grant the approach that is not `last`.
  - req_a only → S_GRANT_A.
  - req_b only → S_GRANT_B.
  - otherwise stay in S_IDLE.
  - Entering S_GRANT_x updates `last` to x.
- S_GRANT_x transitions:
  - occ=1 → S_OCC. This takes priority over a withdrawn request.
  - else req_x=0 (train withdrew) → S_IDLE. `last` keeps x.
  - else stay in S_GRANT_x.
  - The other approach's request is ignored while in S_GRANT_x.
- S_OCC: when occ=0, go to S_FLUSH and load cnt=CLEAR_CYCLES-1.
- S_FLUSH transitions:
  - occ=1 → S_OCC. The count is abandoned and reloaded on the next entry to S_FLUSH.
  - else cnt==0 → S_IDLE.
  - else decrement cnt.
  - Net effect: S_FLUSH lasts exactly CLEAR_CYCLES cycles when occ stays low.
- Lamps are a combinational function of state, `last`, req_a and req_b:
  - S_GRANT_A: A green, B red.
  - S_GRANT_B: B green, A red.
  - S_IDLE and S_OCC: both red.
  - S_FLUSH: the approach that would win arbitration if S_IDLE applied to the current req_a/req_b shows yellow; the other shows red. If neither request is high, both show red.
- busy = (state != S_IDLE).
- An unreachable state encoding decodes as S_OCC (both lamps red) and goes to S_FLUSH on the next occ=0.

## Timing
- Reset, synchronous on a clk edge with rstn=0:
  - state=S_IDLE, last=1 (so A wins the first tie), cnt=0, fault=0.
  - Outputs during and after reset: red_a=red_b=1, all green and yellow 0, busy=0, fault=0.
  - Reset mid-operation, in any state, returns to these values on the next edge, including clearing fault.
- Grant latency: a request sampled high at edge t while in S_IDLE gives green at the output after edge t, i.e. 1 cycle.
- Green drops to red on the edge after occ is first sampled high, i.e. 1 cycle.
- Turnaround: with occ falling before edge t and the other request already pending, the sequence is:
  - S_FLUSH for CLEAR_CYCLES cycles, with yellow on the waiting approach;
  - then 1 cycle of S_IDLE;
  - then green.
  - Minimum red-to-green gap after occ falls is CLEAR_CYCLES+1 cycles.
- Simultaneous events:
  - Both requests rising on the same edge in S_IDLE are resolved by `last`.
  - occ and a request both high in S_IDLE: the intrusion wins (S_OCC, fault=1).
  - req withdrawn on the same edge occ rises in S_GRANT_x: go to S_OCC.
- Two greens are never asserted in the same cycle. Green is never asserted while occ was sampled high on the previous edge.

## Test plan
- Reset: hold rstn=0 for 2 cycles with req_a=req_b=occ=1 → both red, busy=0, fault=0. Release with all inputs 0 → remains S_IDLE.
- Single pass, CLEAR_CYCLES=4: req_a=1 → green_a on the next cycle. occ=1 → red_a on the next cycle. occ=0 → busy stays high for 4 S_FLUSH cycles plus 1 S_IDLE cycle, then busy=0.
- Tie and fairness: req_a=req_b=1 from reset → A granted first. A completes its pass while req_b is held → yellow_b for 4 cycles, then green_b. Repeat with A requesting again → A granted next, so grants alternate.
- Withdrawal: in S_GRANT_B, drop req_b with occ=0 → S_IDLE next cycle, both red. A later tie grants A, since last=B.
- Re-occupation in flush: after occ falls, reassert occ at flush cycle 2 → back to S_OCC, both red. Drop occ → full 4-cycle flush restarts.
- Intrusion: in S_IDLE with no grant, pulse occ=1 → fault=1 and S_OCC. After occ falls and the flush completes, fault stays 1 until rstn=0.

Source files
------------

// File: rtl/junction_ctrl_if.sv
// Signal bundle between the junction controller and the trackside equipment:
// approach requests and occupancy in, lamp drives and status out.
interface junction_ctrl_if;
    logic req_a;
    logic req_b;
    logic occ;
    logic green_a;
    logic yellow_a;
    logic red_a;
    logic green_b;
    logic yellow_b;
    logic red_b;
    logic busy;
    logic fault;

    // Trackside / environment side: drives requests and occupancy, sees lamps.
    modport master (
        output req_a, req_b, occ,
        input  green_a, yellow_a, red_a, green_b, yellow_b, red_b, busy, fault
    );

    // Controller side.
    modport slave (
        input  req_a, req_b, occ,
        output green_a, yellow_a, red_a, green_b, yellow_b, red_b, busy, fault
    );
endinterface

// File: rtl/junction_ctrl.sv
// Junction controller: round-robin grant of a single-track shared section to
// approach A or B, red while occupied, a clearance flush after the train
// leaves, and a sticky fault flag for any entry made without a grant.
module junction_ctrl #(
    parameter int CLEAR_CYCLES = 4
) (
    input  logic            clk,
    input  logic            rstn,
    junction_ctrl_if.slave  jif
);
    localparam int CW = $clog2(CLEAR_CYCLES + 1);
    localparam logic [CW-1:0] CNT_LOAD = CW'(CLEAR_CYCLES - 1);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_GRANT_A = 3'd1,
        S_GRANT_B = 3'd2,
        S_OCC     = 3'd3,
        S_FLUSH   = 3'd4
    } state_t;

    state_t          r_state;
    logic            r_last;   // most recent grant: 0 = A, 1 = B
    logic [CW-1:0]   r_cnt;
    logic            r_fault;

    logic            w_win_a;
    logic            w_win_b;

    // Arbitration winner for the current requests; a tie goes to the approach not granted last.
    always_comb begin
        w_win_a = jif.req_a & (~jif.req_b | r_last);
        w_win_b = jif.req_b & (~jif.req_a | ~r_last);
    end

    // Sequencer: grant, occupancy, clearance flush and fault capture.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            r_state <= S_IDLE;
            r_last  <= 1'b1;
            r_cnt   <= '0;
            r_fault <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (jif.occ) begin
                        // Train entered with no grant outstanding.
                        r_state <= S_OCC;
                        r_fault <= 1'b1;
                    end else if (w_win_a) begin
                        r_state <= S_GRANT_A;
                        r_last  <= 1'b0;
                    end else if (w_win_b) begin
                        r_state <= S_GRANT_B;
                        r_last  <= 1'b1;
                    end
                end
                S_GRANT_A: begin
                    if (jif.occ)
                        r_state <= S_OCC;
                    else if (!jif.req_a)
                        r_state <= S_IDLE;
                end
                S_GRANT_B: begin
                    if (jif.occ)
                        r_state <= S_OCC;
                    else if (!jif.req_b)
                        r_state <= S_IDLE;
                end
                S_FLUSH: begin
                    if (jif.occ)
                        r_state <= S_OCC;
                    else if (r_cnt == '0)
                        r_state <= S_IDLE;
                    else
                        r_cnt <= r_cnt - CW'(1);
                end
                default: begin
                    // S_OCC, and any unreachable encoding treated as occupied.
                    if (!jif.occ) begin
                        r_state <= S_FLUSH;
                        r_cnt   <= CNT_LOAD;
                    end else begin
                        r_state <= S_OCC;
                    end
                end
            endcase
        end
    end

    // Lamp decode: green on grant, yellow during flush for the pending winner, red otherwise.
    always_comb begin
        jif.green_a  = 1'b0;
        jif.yellow_a = 1'b0;
        jif.red_a    = 1'b1;
        jif.green_b  = 1'b0;
        jif.yellow_b = 1'b0;
        jif.red_b    = 1'b1;
        case (r_state)
            S_GRANT_A: begin
                jif.green_a = 1'b1;
                jif.red_a   = 1'b0;
            end
            S_GRANT_B: begin
                jif.green_b = 1'b1;
                jif.red_b   = 1'b0;
            end
            S_FLUSH: begin
                if (w_win_a) begin
                    jif.yellow_a = 1'b1;
                    jif.red_a    = 1'b0;
                end
                if (w_win_b) begin
                    jif.yellow_b = 1'b1;
                    jif.red_b    = 1'b0;
                end
            end
            default: ;
        endcase
    end

    assign jif.busy  = (r_state != S_IDLE);
    assign jif.fault = r_fault;

endmodule

// File: tb/tb_junction_ctrl.sv
// Bench for junction_ctrl: a directed table of hand-derived vectors covering
// reset, a single pass, tie/fairness, withdrawal, flush restart and intrusion,
// followed by random traffic checked against a behavioural model.
module tb_junction_ctrl;
    localparam int CLEAR = 4;

    localparam logic [5:0] RR = 6'b001_001;  // {ga,ya,ra,gb,yb,rb}
    localparam logic [5:0] GA = 6'b100_001;
    localparam logic [5:0] GB = 6'b001_100;
    localparam logic [5:0] YA = 6'b010_001;
    localparam logic [5:0] YB = 6'b001_010;

    logic clk;
    logic rstn;

    junction_ctrl_if jif ();

    junction_ctrl #(.CLEAR_CYCLES(CLEAR)) dut (
        .clk  (clk),
        .rstn (rstn),
        .jif  (jif.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic       rstn;
        logic       a;
        logic       b;
        logic       o;
        bit         chk;
        logic [5:0] lamps;
        logic       busy;
        logic       fault;
    } vec_t;

    vec_t vt[$];
    int   n_tests = 0;
    int   n_fail  = 0;

    // Behavioural reference: which approach holds a grant (-1 none), whether
    // the section is occupied, cycles of clearance still owed, fault, last grant.
    int m_grant;
    bit m_occ;
    int m_flush;
    bit m_fault;
    int m_last;

    task automatic model_reset();
        m_grant = -1; m_occ = 0; m_flush = 0; m_fault = 0; m_last = 1;
    endtask

    function automatic int pick(input logic a, input logic b);
        if (a && b) return (m_last == 1) ? 0 : 1;
        if (a) return 0;
        if (b) return 1;
        return -1;
    endfunction

    task automatic model_step(input logic r, input logic a, input logic b, input logic o);
        int w;
        if (!r) begin
            model_reset();
        end else if (m_occ) begin
            if (!o) begin m_occ = 0; m_flush = CLEAR; end
        end else if (m_flush > 0) begin
            if (o) begin m_flush = 0; m_occ = 1; end
            else m_flush = m_flush - 1;
        end else if (m_grant >= 0) begin
            if (o) begin m_grant = -1; m_occ = 1; end
            else if ((m_grant == 0 && !a) || (m_grant == 1 && !b)) m_grant = -1;
        end else begin
            w = pick(a, b);
            if (o) begin m_occ = 1; m_fault = 1; end
            else if (w >= 0) begin m_grant = w; m_last = w; end
        end
    endtask

    function automatic logic [5:0] model_lamps(input logic a, input logic b);
        int w;
        if (m_grant == 0) return GA;
        if (m_grant == 1) return GB;
        if (m_flush > 0) begin
            w = pick(a, b);
            if (w == 0) return YA;
            if (w == 1) return YB;
        end
        return RR;
    endfunction

    function automatic logic model_busy();
        return (m_occ || m_flush > 0 || m_grant >= 0);
    endfunction

    task automatic add(input int n, input logic r, input logic a, input logic b, input logic o,
                       input bit c, input logic [5:0] l, input logic bz, input logic f);
        vec_t v;
        v.rstn = r; v.a = a; v.b = b; v.o = o; v.chk = c;
        v.lamps = l; v.busy = bz; v.fault = f;
        for (int k = 0; k < n; k++) vt.push_back(v);
    endtask

    task automatic apply(input logic r, input logic a, input logic b, input logic o);
        @(negedge clk);
        rstn = r; jif.req_a = a; jif.req_b = b; jif.occ = o;
        #1;
    endtask

    task automatic check(input string nm, input int idx, input logic [5:0] el,
                         input logic eb, input logic ef);
        logic [5:0] al;
        al = {jif.green_a, jif.yellow_a, jif.red_a, jif.green_b, jif.yellow_b, jif.red_b};
        n_tests++;
        if (al !== el || jif.busy !== eb || jif.fault !== ef) begin
            n_fail++;
            $display("FAIL %s #%0d: got lamps=%b busy=%b fault=%b, want lamps=%b busy=%b fault=%b",
                     nm, idx, al, jif.busy, jif.fault, el, eb, ef);
        end
    endtask

    initial begin
        logic ra, rb, ro, rr;

        rstn = 1'b0; jif.req_a = 1'b0; jif.req_b = 1'b0; jif.occ = 1'b0;
        model_reset();

        // reset held with all inputs high, then released idle
        add(1, 0, 1, 1, 1, 0, RR, 0, 0);
        add(1, 0, 1, 1, 1, 1, RR, 0, 0);
        add(2, 1, 0, 0, 0, 1, RR, 0, 0);
        // single pass on A
        add(1, 1, 1, 0, 0, 1, RR, 0, 0);
        add(1, 1, 1, 0, 0, 1, GA, 1, 0);
        add(1, 1, 1, 0, 1, 1, GA, 1, 0);
        add(1, 1, 0, 0, 1, 1, RR, 1, 0);
        add(1, 1, 0, 0, 0, 1, RR, 1, 0);
        add(4, 1, 0, 0, 0, 1, RR, 1, 0);
        add(1, 1, 0, 0, 0, 1, RR, 0, 0);
        // tie from reset: A first, then B after yellow, then A again
        add(1, 0, 0, 0, 0, 1, RR, 0, 0);
        add(1, 1, 1, 1, 0, 1, RR, 0, 0);
        add(1, 1, 1, 1, 0, 1, GA, 1, 0);
        add(1, 1, 1, 1, 1, 1, GA, 1, 0);
        add(1, 1, 0, 1, 1, 1, RR, 1, 0);
        add(1, 1, 0, 1, 0, 1, RR, 1, 0);
        add(4, 1, 0, 1, 0, 1, YB, 1, 0);
        add(1, 1, 0, 1, 0, 1, RR, 0, 0);
        add(1, 1, 1, 1, 0, 1, GB, 1, 0);
        add(1, 1, 1, 1, 1, 1, GB, 1, 0);
        add(1, 1, 1, 0, 1, 1, RR, 1, 0);
        add(1, 1, 1, 0, 0, 1, RR, 1, 0);
        add(4, 1, 1, 0, 0, 1, YA, 1, 0);
        add(1, 1, 1, 1, 0, 1, RR, 0, 0);
        add(1, 1, 1, 1, 0, 1, GA, 1, 0);
        // withdrawals, then a tie after B goes to A
        add(1, 1, 0, 1, 0, 1, GA, 1, 0);
        add(1, 1, 0, 1, 0, 1, RR, 0, 0);
        add(1, 1, 0, 0, 0, 1, GB, 1, 0);
        add(1, 1, 1, 1, 0, 1, RR, 0, 0);
        add(1, 1, 0, 0, 0, 1, GA, 1, 0);
        // re-occupation at flush cycle 2 restarts the full flush
        add(1, 1, 1, 0, 0, 1, RR, 0, 0);
        add(1, 1, 1, 0, 1, 1, GA, 1, 0);
        add(1, 1, 0, 0, 1, 1, RR, 1, 0);
        add(1, 1, 0, 0, 0, 1, RR, 1, 0);
        add(1, 1, 0, 0, 0, 1, RR, 1, 0);
        add(1, 1, 0, 0, 1, 1, RR, 1, 0);
        add(1, 1, 0, 0, 0, 1, RR, 1, 0);
        add(4, 1, 0, 0, 0, 1, RR, 1, 0);
        // intrusion from idle: fault is sticky until reset
        add(1, 1, 0, 0, 1, 1, RR, 0, 0);
        add(1, 1, 0, 0, 0, 1, RR, 1, 1);
        add(4, 1, 0, 0, 0, 1, RR, 1, 1);
        add(1, 1, 0, 0, 0, 1, RR, 0, 1);
        add(1, 0, 0, 0, 0, 1, RR, 0, 1);
        // intrusion beats a simultaneous request
        add(1, 1, 1, 0, 1, 1, RR, 0, 0);
        add(1, 1, 1, 0, 1, 1, RR, 1, 1);

        foreach (vt[i]) begin
            apply(vt[i].rstn, vt[i].a, vt[i].b, vt[i].o);
            if (vt[i].chk) check("directed", i, vt[i].lamps, vt[i].busy, vt[i].fault);
            @(posedge clk);
            model_step(vt[i].rstn, vt[i].a, vt[i].b, vt[i].o);
        end

        ra = 1'b0; rb = 1'b0; ro = 1'b0;
        for (int c = 0; c < 1500; c++) begin
            if ($urandom_range(0, 99) < 15) ra = ~ra;
            if ($urandom_range(0, 99) < 15) rb = ~rb;
            if ($urandom_range(0, 99) < 12) ro = ~ro;
            rr = ($urandom_range(0, 99) < 2) ? 1'b0 : 1'b1;
            apply(rr, ra, rb, ro);
            check("random", c, model_lamps(ra, rb), model_busy(), m_fault);
            @(posedge clk);
            model_step(rr, ra, rb, ro);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
